// File: rtl/pcm_pkg.sv
// pcm_pkg: shared types and default widths for the microphone PCM path.
//   pcm_state_t : sequencer state encoding (IDLE, FLUSH, REC, PLAY = 0..3)
//   PCM_*       : default parameter values shared by the mic, FIFO and
//                 sequencer blocks.
package pcm_pkg;

  localparam int PCM_ADR_WIDTH = 12;
  localparam int PCM_DAT_WIDTH = 6;
  localparam int PCM_PLAY_DIV  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REC   = 2'd2,
    PLAY  = 2'd3
  } pcm_state_t;

endpackage

// File: rtl/pcm_tick_gen.sv
// pcm_tick_gen: playback sample-rate divider.
//   mclk  in  clock
//   reset in  async, active-low
//   clr   in  synchronous clear (wins over en)
//   en    in  count enable
//   tick  out 1-cycle strobe on the terminal count (PLAY_DIV-1)
// The counter runs 0..PLAY_DIV-1 and wraps; tick is combinational from the
// count so the owner can act in the terminal cycle itself.
module pcm_tick_gen #(
  parameter int PLAY_DIV = 64
) (
  input  logic mclk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PLAY_DIV > 1) ? $clog2(PLAY_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(PLAY_DIV - 1));

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/pcm_fifo_ctrl.sv
// pcm_fifo_ctrl: record/playback sequencer for the mic PCM sample FIFO.
//   mclk, reset         clock, async active-low reset
//   rec_start           request: flush FIFO, then record
//   play_start          request: play FIFO contents at mclk/PLAY_DIV
//   stop                request: abort to IDLE from any state (no done)
//   mic_valid/mic_data  mic sample strobe and data
//   fifo_full/empty     FIFO flags
//   fifo_dout           FIFO head data (combinational from read pointer)
//   fifo_wr/rd/din      registered FIFO strobes and write data
//   pcm_out/pcm_valid   playback sample and its 1-cycle strobe
//   state               0 IDLE, 1 FLUSH, 2 REC, 3 PLAY
//   sample_cnt          samples written (REC) / read (PLAY), saturating
//   overrun             sticky: a mic sample was dropped on a full FIFO
//   done                1-cycle pulse when REC or PLAY ends on its own
// Build option: MONITOR_EN copies every accepted mic sample to pcm_out with
// pcm_valid alongside fifo_wr (live monitoring). Without it pcm_out and
// pcm_valid only move in PLAY.
module pcm_fifo_ctrl
  import pcm_pkg::*;
#(
  parameter int ADR_WIDTH = PCM_ADR_WIDTH,
  parameter int DAT_WIDTH = PCM_DAT_WIDTH,
  parameter int PLAY_DIV  = PCM_PLAY_DIV
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 rec_start,
  input  logic                 play_start,
  input  logic                 stop,
  input  logic                 mic_valid,
  input  logic [DAT_WIDTH-1:0] mic_data,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [DAT_WIDTH-1:0] fifo_dout,
  output logic                 fifo_wr,
  output logic                 fifo_rd,
  output logic [DAT_WIDTH-1:0] fifo_din,
  output logic [DAT_WIDTH-1:0] pcm_out,
  output logic                 pcm_valid,
  output logic [1:0]           state,
  output logic [ADR_WIDTH:0]   sample_cnt,
  output logic                 overrun,
  output logic                 done
);

  localparam logic [ADR_WIDTH:0] CNT_MAX = {1'b1, {ADR_WIDTH{1'b0}}};

  pcm_state_t st, st_nxt;
  logic       tick;
  logic       flush_rd, play_rd, wr_acc, ovr_hit, play_end;
  // vld_pipe[0]: FIFO read cycle N, vld_pipe[1]: pcm_out presented in N+1
  logic [1:0] vld_pipe;

  assign state = st;

  pcm_tick_gen #(.PLAY_DIV(PLAY_DIV)) u_tick (
    .mclk  (mclk),
    .reset (reset),
    .clr   (st != PLAY),
    .en    (st == PLAY),
    .tick  (tick)
  );

  always_comb begin
    st_nxt   = st;
    flush_rd = 1'b0;
    play_rd  = 1'b0;
    wr_acc   = 1'b0;
    ovr_hit  = 1'b0;
    play_end = 1'b0;
    if (stop) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE: begin
          if (rec_start)       st_nxt = FLUSH;
          else if (play_start) st_nxt = PLAY;
        end
        FLUSH: begin
          // The empty flag trails a read by a cycle, so a new read is only
          // issued when none is in flight; otherwise the last entry would be
          // read twice.
          if (fifo_empty) st_nxt = REC;
          else            flush_rd = !fifo_rd;
        end
        REC: begin
          if (mic_valid) begin
            if (fifo_full) begin
              ovr_hit = 1'b1;
              st_nxt  = IDLE;
            end else begin
              wr_acc = 1'b1;
            end
          end
        end
        PLAY: begin
          if (tick) begin
            if (fifo_empty) begin
              play_end = 1'b1;
              st_nxt   = IDLE;
            end else begin
              play_rd = 1'b1;
            end
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

`ifdef MONITOR_EN
  logic mon_vld;
  assign pcm_valid = vld_pipe[1] | mon_vld;
`else
  assign pcm_valid = vld_pipe[1];
`endif

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      st         <= IDLE;
      fifo_wr    <= 1'b0;
      fifo_rd    <= 1'b0;
      fifo_din   <= '0;
      pcm_out    <= '0;
      sample_cnt <= '0;
      overrun    <= 1'b0;
      done       <= 1'b0;
      vld_pipe   <= '0;
`ifdef MONITOR_EN
      mon_vld    <= 1'b0;
`endif
    end else begin
      st       <= st_nxt;
      fifo_wr  <= wr_acc;
      fifo_rd  <= flush_rd | play_rd;
      done     <= ovr_hit | play_end;
      vld_pipe <= {vld_pipe[0], play_rd};

      if (wr_acc)      fifo_din <= mic_data;
      if (vld_pipe[0]) pcm_out  <= fifo_dout;
      if (ovr_hit)     overrun  <= 1'b1;

      if (st == FLUSH && st_nxt == REC) begin
        sample_cnt <= '0;
        overrun    <= 1'b0;
      end else if (st == IDLE && st_nxt == PLAY) begin
        sample_cnt <= '0;
      end else if (wr_acc || vld_pipe[0]) begin
        if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
      end

`ifdef MONITOR_EN
      mon_vld <= wr_acc;
      if (wr_acc) pcm_out <= mic_data;
`endif
    end
  end

endmodule

// File: tb/tb_pcm_fifo_ctrl.sv
module tb_pcm_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 6;
  localparam int DIV   = 4;
  localparam int DEPTH = 16;

  logic          mclk = 1'b0;
  logic          reset = 1'b0;
  logic          rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
  logic          mic_valid = 1'b0;
  logic [DW-1:0] mic_data = '0;
  logic          fifo_full, fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_wr, fifo_rd;
  logic [DW-1:0] fifo_din, pcm_out;
  logic          pcm_valid, overrun, done;
  logic [1:0]    state;
  logic [AW:0]   sample_cnt;

  int passed = 0;
  int total  = 0;

  always #5 mclk = ~mclk;

  pcm_fifo_ctrl #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .PLAY_DIV(DIV)) dut (
    .mclk       (mclk),
    .reset      (reset),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .mic_valid  (mic_valid),
    .mic_data   (mic_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_wr    (fifo_wr),
    .fifo_rd    (fifo_rd),
    .fifo_din   (fifo_din),
    .pcm_out    (pcm_out),
    .pcm_valid  (pcm_valid),
    .state      (state),
    .sample_cnt (sample_cnt),
    .overrun    (overrun),
    .done       (done)
  );

  // FIFO model; tb_wr lets the bench preload entries while the DUT idles.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0]   cnt;
  logic          force_full = 1'b0;
  logic          tb_wr = 1'b0;
  logic [DW-1:0] tb_din = '0;
  logic          mwr;

  assign mwr        = fifo_wr | tb_wr;
  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == (AW+1)'(DEPTH)) || force_full;
  assign fifo_dout  = mem[rp];

  always @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (mwr) begin
        mem[wp] <= fifo_wr ? fifo_din : tb_din;
        wp      <= wp + 1'b1;
      end
      if (fifo_rd) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, mwr} - {{AW{1'b0}}, fifo_rd};
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic preload(input logic [DW-1:0] v);
    tb_wr  = 1'b1;
    tb_din = v;
    tick();
    tb_wr  = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
    total++; if ({fifo_wr, fifo_rd, pcm_valid, overrun, done} !== 5'b0)
      $display("FAIL reset_strobes: got %b want 00000", {fifo_wr, fifo_rd, pcm_valid, overrun, done}); else passed++;
    total++; if ({fifo_din, pcm_out, sample_cnt} !== '0)
      $display("FAIL reset_data: din %h pcm %h cnt %0d want 0", fifo_din, pcm_out, sample_cnt); else passed++;
    @(negedge mclk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_record();
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    total++; if (state !== 2'd1) $display("FAIL rec_flush_entry: got %0d want 1", state); else passed++;
    for (int i = 0; i < 10 && state != 2'd2; i++) tick();
    total++; if (state !== 2'd2) $display("FAIL rec_entry: got %0d want 2", state); else passed++;
    for (int k = 1; k <= 5; k++) begin
      mic_data = DW'(k); mic_valid = 1'b1; tick(); mic_valid = 1'b0;
      total++; if (fifo_wr !== 1'b1 || fifo_din !== DW'(k) || sample_cnt !== (AW+1)'(k) || done !== 1'b0)
        $display("FAIL rec_write%0d: wr %b din %h cnt %0d done %b want 1 %h %0d 0", k, fifo_wr, fifo_din, sample_cnt, done, k, k);
      else passed++;
`ifdef MONITOR_EN
      total++; if (pcm_valid !== 1'b1 || pcm_out !== DW'(k))
        $display("FAIL rec_monitor%0d: valid %b pcm %h want 1 %h", k, pcm_valid, pcm_out, k); else passed++;
`else
      total++; if (pcm_valid !== 1'b0) $display("FAIL rec_no_monitor%0d: valid %b want 0", k, pcm_valid); else passed++;
`endif
      tick();
      total++; if (fifo_wr !== 1'b0 || done !== 1'b0)
        $display("FAIL rec_gap%0d: wr %b done %b want 0 0", k, fifo_wr, done); else passed++;
    end
    stop = 1'b1; tick(); stop = 1'b0;
    total++; if (state !== 2'd0 || done !== 1'b0)
      $display("FAIL rec_stop: state %0d done %b want 0 0", state, done); else passed++;
    total++; if (sample_cnt !== 5'd5 || cnt !== 5'd5)
      $display("FAIL rec_count: cnt %0d fifo %0d want 5 5", sample_cnt, cnt); else passed++;
  endtask

  task automatic test_play();
    int nval, nrd, done_cyc;
    nval = 0; nrd = 0; done_cyc = -1;
    play_start = 1'b1; tick(); play_start = 1'b0;
    total++; if (state !== 2'd3 || sample_cnt !== 5'd0)
      $display("FAIL play_entry: state %0d cnt %0d want 3 0", state, sample_cnt); else passed++;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (fifo_rd) nrd++;
      if (pcm_valid) begin
        total++;
        if (c != 5 + 4*nval || pcm_out !== DW'(nval+1) || sample_cnt !== (AW+1)'(nval+1))
          $display("FAIL play_sample%0d: cycle %0d pcm %h cnt %0d want cycle %0d pcm %h cnt %0d",
                   nval+1, c, pcm_out, sample_cnt, 5+4*nval, nval+1, nval+1);
        else passed++;
        nval++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    total++; if (nval != 5 || nrd != 5)
      $display("FAIL play_counts: samples %0d reads %0d want 5 5", nval, nrd); else passed++;
    total++; if (done_cyc != 24 || state !== 2'd0)
      $display("FAIL play_done: cycle %0d state %0d want 24 0", done_cyc, state); else passed++;
    tick();
    total++; if (done !== 1'b0 || pcm_valid !== 1'b0 || pcm_out !== 6'h05)
      $display("FAIL play_hold: done %b valid %b pcm %h want 0 0 05", done, pcm_valid, pcm_out); else passed++;
  endtask

  task automatic test_flush();
    int nrd;
    nrd = 0;
    preload(6'h3A); preload(6'h3B); preload(6'h3C);
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    total++; if (state !== 2'd1) $display("FAIL flush_entry: got %0d want 1", state); else passed++;
    for (int i = 0; i < 30; i++) begin
      if (state == 2'd2) break;
      if (fifo_rd) nrd++;
      tick();
    end
    total++; if (nrd != 3) $display("FAIL flush_reads: got %0d want 3", nrd); else passed++;
    total++; if (state !== 2'd2 || sample_cnt !== 5'd0 || cnt !== 5'd0)
      $display("FAIL flush_exit: state %0d cnt %0d fifo %0d want 2 0 0", state, sample_cnt, cnt); else passed++;
  endtask

  task automatic test_overrun();
    force_full = 1'b1;
    mic_data = 6'h2A; mic_valid = 1'b1; tick(); mic_valid = 1'b0;
    total++; if (fifo_wr !== 1'b0 || overrun !== 1'b1 || done !== 1'b1 || state !== 2'd0)
      $display("FAIL ovr_hit: wr %b ovr %b done %b state %0d want 0 1 1 0", fifo_wr, overrun, done, state); else passed++;
    tick();
    total++; if (done !== 1'b0 || overrun !== 1'b1)
      $display("FAIL ovr_sticky: done %b ovr %b want 0 1", done, overrun); else passed++;
    force_full = 1'b0;
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    total++; if (state !== 2'd1 || overrun !== 1'b1)
      $display("FAIL ovr_in_flush: state %0d ovr %b want 1 1", state, overrun); else passed++;
    for (int i = 0; i < 10 && state != 2'd2; i++) tick();
    total++; if (state !== 2'd2 || overrun !== 1'b0)
      $display("FAIL ovr_clear: state %0d ovr %b want 2 0", state, overrun); else passed++;
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_priority();
    rec_start = 1'b1; play_start = 1'b1; tick(); rec_start = 1'b0; play_start = 1'b0;
    total++; if (state !== 2'd1) $display("FAIL prio_rec_over_play: got %0d want 1", state); else passed++;
    tick();
    play_start = 1'b1; tick(); play_start = 1'b0;
    total++; if (state !== 2'd2) $display("FAIL prio_ignore_in_rec: got %0d want 2", state); else passed++;
    stop = 1'b1; tick(); stop = 1'b0;
    stop = 1'b1; rec_start = 1'b1; tick(); stop = 1'b0; rec_start = 1'b0;
    total++; if (state !== 2'd0 || done !== 1'b0)
      $display("FAIL prio_stop_over_rec: state %0d done %b want 0 0", state, done); else passed++;
  endtask

  task automatic test_reset_mid_play();
    preload(6'h11); preload(6'h22);
    play_start = 1'b1; tick(); play_start = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    total++; if (pcm_valid !== 1'b1 || pcm_out !== 6'h11 || state !== 2'd3)
      $display("FAIL rst_pre: valid %b pcm %h state %0d want 1 11 3", pcm_valid, pcm_out, state); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (pcm_valid !== 1'b0 || pcm_out !== '0 || state !== 2'd0 || sample_cnt !== '0 || fifo_rd !== 1'b0)
      $display("FAIL rst_async: valid %b pcm %h state %0d cnt %0d rd %b want all 0",
               pcm_valid, pcm_out, state, sample_cnt, fifo_rd); else passed++;
    @(negedge mclk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_record();
    test_play();
    test_flush();
    test_overrun();
    test_priority();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
